// File: rtl/ram_endpoint.sv
// ram_endpoint: word-addressed RAM behind a request/ack packet port.
// Ports: clk, rst_n (sync, active-low), rou_in/ack_in (requests),
//   rou_out/ack_out (responses), err_cnt (saturating), rq_level.
module ram_endpoint #(
   parameter int DWID  = 128,
   parameter int AWID  = 32,
   parameter int CWID  = 8,
   parameter int WID   = 2 + DWID + AWID + CWID,
   parameter int DEPTH = 1024,
   parameter int BASE  = 0,
   parameter int RLAT  = 1,
   parameter int RQD   = 4,
   parameter int WRSP  = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WID-1:0]           rou_in,
   output logic [2:0]               ack_in,
   output logic [WID-1:0]           rou_out,
   input  logic [2:0]               ack_out,
   output logic [15:0]              err_cnt,
   output logic [$clog2(RQD+1)-1:0] rq_level
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(RQD);
   localparam int LW = $clog2(RQD + 1);
   localparam logic [AWID:0] LO = (AWID+1)'(64'(BASE));
   localparam logic [AWID:0] HI = (AWID+1)'(64'(BASE) + 64'(DEPTH));

   // request fields
   logic [1:0]      cmd;
   logic [CWID-1:0] tag;
   logic [AWID-1:0] addr;
   logic [DWID-1:0] wdat;
   logic            in_rng;
   logic [IW-1:0]   idx;

   assign cmd  = rou_in[WID-1 -: 2];
   assign tag  = rou_in[WID-3 -: CWID];
   assign addr = rou_in[DWID +: AWID];
   assign wdat = rou_in[DWID-1:0];

   assign in_rng = ({1'b0, addr} >= LO) &&
                   ({1'b0, addr} <  HI);
   assign idx    = IW'({1'b0, addr} - LO);

   // storage
   logic [DWID-1:0] mem [DEPTH];

   // Response queue: a slot is reserved at acceptance so
   // responses leave in acceptance order; q_rdy marks slots
   // whose payload is complete (reads finish RLAT later).
   logic [WID-1:0] q_pkt [RQD];
   logic [RQD-1:0] q_rdy;
   logic [PW-1:0]  wp;
   logic [PW-1:0]  rp;
   logic [LW-1:0]  lvl;

   // read pipeline: valid bits plus the reserved slot
   logic [RLAT-1:0] pv;
   logic [PW-1:0]   ps [RLAT];

   // request decode
   logic       is_wr;
   logic       is_rd;
   logic       bad;
   logic       needq;
   logic       full;
   logic       busy;
   logic       ok;
   logic       wr_go;
   logic       rd_go;
   logic       alloc;
   logic [2:0] ack_d;

   assign is_wr = (cmd == 2'b01);
   assign is_rd = (cmd == 2'b10);
   assign full  = (lvl == LW'(RQD));
   assign bad   = (cmd == 2'b11) |
                  ((is_wr | is_rd) & !in_rng);
   assign needq = is_rd | (is_wr & (WRSP != 0));
   assign busy  = !bad & needq & full;
   assign ok    = (is_wr | is_rd) & !bad & !busy;
   assign wr_go = rst_n & ok & is_wr;
   assign rd_go = rst_n & ok & is_rd;
   assign alloc = rst_n & ok & needq;

   always_comb begin
      ack_d = 3'b000;
      unique case (1'b1)
         (cmd == 2'b00): ack_d = 3'b000;
         bad:            ack_d = 3'b100;
         busy:           ack_d = 3'b010;
         ok:             ack_d = 3'b001;
         default:        ack_d = 3'b000;
      endcase
   end

   // response side: anything but 001/100 holds the head
   logic        head_rdy;
   logic        pop;
   logic        drop;
   logic [1:0]  inc;
   logic [16:0] err_sum;

   assign head_rdy = q_rdy[rp];
   assign drop     = head_rdy & (ack_out == 3'b100);
   assign pop      = drop | (head_rdy & (ack_out == 3'b001));
   assign rou_out  = head_rdy ? q_pkt[rp] : '0;
   assign rq_level = lvl;

   // both sides may raise an error in the same cycle
   assign inc     = 2'(bad) + 2'(drop);
   assign err_sum = {1'b0, err_cnt} + 17'(inc);

   function automatic logic [PW-1:0] nxt(
      input logic [PW-1:0] p
   );
      return (p == PW'(RQD - 1)) ? '0 : p + 1'b1;
   endfunction

   // memory and slot payloads are not reset
   always_ff @(posedge clk) begin
      if (wr_go) begin
         mem[idx] <= wdat;
      end
      if (alloc) begin
         q_pkt[wp] <= {2'b11, tag, addr,
                       is_rd ? mem[idx] : {DWID{1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      ps[0] <= wp;
      for (int k = 1; k < RLAT; k++) begin
         ps[k] <= ps[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_in  <= '0;
         q_rdy   <= '0;
         wp      <= '0;
         rp      <= '0;
         lvl     <= '0;
         pv      <= '0;
         err_cnt <= '0;
      end else begin
         ack_in <= ack_d;
         pv[0]  <= rd_go;
         for (int k = 1; k < RLAT; k++) begin
            pv[k] <= pv[k-1];
         end
         if (pop) begin
            q_rdy[rp] <= 1'b0;
            rp        <= nxt(rp);
         end
         if (alloc & is_wr) begin
            q_rdy[wp] <= 1'b1;
         end
         if (pv[RLAT-1]) begin
            q_rdy[ps[RLAT-1]] <= 1'b1;
         end
         if (alloc) begin
            wp <= nxt(wp);
         end
         lvl <= lvl + LW'(alloc) - LW'(pop);
         err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

endmodule

// File: tb/tb_ram_endpoint.sv
// tb_ram_endpoint: directed checks of ram_endpoint.
// Instance a: RLAT 2, RQD 4, WRSP 1; instance b: RQD 8, WRSP 0.
module tb_ram_endpoint;

   logic        clk;
   logic        rst_n;
   logic [53:0] rin_a;
   logic [2:0]  ack_in_a;
   logic [53:0] rou_a;
   logic [2:0]  ack_out_a;
   logic [15:0] err_a;
   logic [2:0]  lvl_a;
   logic [53:0] rin_b;
   logic [2:0]  ack_in_b;
   logic [53:0] rou_b;
   logic [2:0]  ack_out_b;
   logic [15:0] err_b;
   logic [3:0]  lvl_b;

   int n_chk = 0;
   int n_err = 0;

   ram_endpoint #(
      .DWID(32), .AWID(16), .CWID(4), .DEPTH(64),
      .BASE('h100), .RLAT(2), .RQD(4), .WRSP(1)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .rou_in(rin_a), .ack_in(ack_in_a),
      .rou_out(rou_a), .ack_out(ack_out_a),
      .err_cnt(err_a), .rq_level(lvl_a)
   );

   ram_endpoint #(
      .DWID(32), .AWID(16), .CWID(4), .DEPTH(64),
      .BASE(0), .RLAT(2), .RQD(8), .WRSP(0)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .rou_in(rin_b), .ack_in(ack_in_b),
      .rou_out(rou_b), .ack_out(ack_out_b),
      .err_cnt(err_b), .rq_level(lvl_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [53:0] pkt(
      input logic [1:0]  c,
      input logic [3:0]  t,
      input logic [15:0] a,
      input logic [31:0] d
   );
      return {c, t, a, d};
   endfunction

   function automatic logic [63:0] rsp(
      input logic [3:0]  t,
      input logic [15:0] a,
      input logic [31:0] d
   );
      return 64'({2'b11, t, a, d});
   endfunction

   task automatic check(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   localparam logic [1:0] WR = 2'b01;
   localparam logic [1:0] RD = 2'b10;
   localparam logic [1:0] RS = 2'b11;

   initial begin
      rst_n     = 1'b0;
      rin_a     = '0;
      rin_b     = '0;
      ack_out_a = 3'b000;
      ack_out_b = 3'b000;
      tick;
      tick;
      check("rst_ack", 64'(ack_in_a), 64'd0);
      check("rst_rou", 64'(rou_a), 64'd0);
      check("rst_err", 64'(err_a), 64'd0);
      check("rst_lvl", 64'(lvl_a), 64'd0);
      rst_n     = 1'b1;
      ack_out_a = 3'b001;

      // write then read back
      rin_a = pkt(WR, 4'd3, 16'h105, 32'hA5);
      tick;
      check("wr_ack", 64'(ack_in_a), 64'd1);
      check("wr_rsp", 64'(rou_a), rsp(4'd3, 16'h105, 32'h0));
      rin_a = pkt(RD, 4'd4, 16'h105, 32'h0);
      tick;
      check("rd_ack", 64'(ack_in_a), 64'd1);
      check("rd_pend", 64'(rou_a), 64'd0);
      check("rd_lvl", 64'(lvl_a), 64'd1);
      rin_a = '0;
      tick;
      check("idle_ack", 64'(ack_in_a), 64'd0);
      check("rd_wait", 64'(rou_a), 64'd0);
      tick;
      check("rd_rsp", 64'(rou_a), rsp(4'd4, 16'h105, 32'hA5));
      tick;
      check("rd_pop", 64'(rou_a), 64'd0);
      check("pop_lvl", 64'(lvl_a), 64'd0);

      // errors
      rin_a = pkt(RD, 4'd1, 16'h140, 32'h0);
      tick;
      check("oor_ack", 64'(ack_in_a), 64'd4);
      check("oor_rou", 64'(rou_a), 64'd0);
      check("oor_err", 64'(err_a), 64'd1);
      rin_a = pkt(RS, 4'd1, 16'h105, 32'h0);
      tick;
      check("rsp_ack", 64'(ack_in_a), 64'd4);
      check("rsp_err", 64'(err_a), 64'd2);
      rin_a = pkt(WR, 4'd1, 16'h0FF, 32'h5);
      tick;
      check("low_ack", 64'(ack_in_a), 64'd4);
      check("low_err", 64'(err_a), 64'd3);

      // acceptance order: read then write
      rin_a = pkt(RD, 4'd5, 16'h105, 32'h0);
      tick;
      rin_a = pkt(WR, 4'd6, 16'h106, 32'h77);
      tick;
      check("ord_ack", 64'(ack_in_a), 64'd1);
      check("ord_hold", 64'(rou_a), 64'd0);
      rin_a = '0;
      tick;
      check("ord_rd", 64'(rou_a), rsp(4'd5, 16'h105, 32'hA5));
      tick;
      check("ord_wr", 64'(rou_a), rsp(4'd6, 16'h106, 32'h0));
      tick;
      check("ord_end", 64'(rou_a), 64'd0);

      // read right after write
      rin_a = pkt(WR, 4'd7, 16'h107, 32'h5A);
      tick;
      rin_a = pkt(RD, 4'd8, 16'h107, 32'h0);
      tick;
      rin_a = '0;
      tick;
      tick;
      check("raw_rsp", 64'(rou_a), rsp(4'd8, 16'h107, 32'h5A));
      tick;
      check("raw_end", 64'(rou_a), 64'd0);

      // fill queue, busy, stable head
      ack_out_a = 3'b010;
      for (int i = 0; i < 6; i++) begin
         rin_a = pkt(RD, 4'(8 + i), 16'h105, 32'h0);
         tick;
         check("full_ack", 64'(ack_in_a),
               (i < 4) ? 64'd1 : 64'd2);
      end
      rin_a = '0;
      tick;
      tick;
      check("full_lvl", 64'(lvl_a), 64'd4);
      check("full_hd", 64'(rou_a), rsp(4'd8, 16'h105, 32'hA5));
      ack_out_a = 3'b011;
      tick;
      check("odd_hd", 64'(rou_a), rsp(4'd8, 16'h105, 32'hA5));
      check("odd_err", 64'(err_a), 64'd3);
      ack_out_a = 3'b001;
      for (int i = 1; i <= 4; i++) begin
         tick;
         check("drain", 64'(rou_a),
               (i < 4) ? rsp(4'(8 + i), 16'h105, 32'hA5)
                       : 64'd0);
      end

      // discard a response
      ack_out_a = 3'b010;
      rin_a = pkt(WR, 4'd1, 16'h100, 32'h1);
      tick;
      rin_a = pkt(RD, 4'd2, 16'h100, 32'h0);
      tick;
      rin_a = '0;
      tick;
      tick;
      check("drp_hd", 64'(rou_a), rsp(4'd1, 16'h100, 32'h0));
      ack_out_a = 3'b100;
      tick;
      check("drp_nxt", 64'(rou_a), rsp(4'd2, 16'h100, 32'h1));
      check("drp_err", 64'(err_a), 64'd4);
      ack_out_a = 3'b001;
      tick;
      check("drp_end", 64'(rou_a), 64'd0);
      check("drp_lvl", 64'(lvl_a), 64'd0);

      // silent writes while queue is full
      ack_out_b = 3'b010;
      rin_b = pkt(WR, 4'd0, 16'h0, 32'h11);
      tick;
      check("sw_ack", 64'(ack_in_b), 64'd1);
      check("sw_rou", 64'(rou_b), 64'd0);
      for (int i = 0; i < 8; i++) begin
         rin_b = pkt(RD, 4'(i), 16'h0, 32'h0);
         tick;
         check("bq_ack", 64'(ack_in_b), 64'd1);
      end
      rin_b = '0;
      tick;
      tick;
      check("bq_lvl", 64'(lvl_b), 64'd8);
      for (int i = 1; i <= 8; i++) begin
         rin_b = pkt(WR, 4'd0, 16'(i), 32'(32'h20 + i));
         tick;
         check("bw_ack", 64'(ack_in_b), 64'd1);
      end
      rin_b = '0;
      tick;
      check("bw_hd", 64'(rou_b), rsp(4'd0, 16'h0, 32'h11));
      check("bw_lvl", 64'(lvl_b), 64'd8);
      ack_out_b = 3'b001;
      for (int i = 1; i <= 8; i++) begin
         tick;
         check("bq_drn", 64'(rou_b),
               (i < 8) ? rsp(4'(i), 16'h0, 32'h11) : 64'd0);
      end
      for (int i = 1; i <= 8; i++) begin
         rin_b = pkt(RD, 4'(i), 16'(i), 32'h0);
         tick;
         rin_b = '0;
         tick;
         tick;
         check("bw_rdbk", 64'(rou_b),
               rsp(4'(i), 16'(i), 32'(32'h20 + i)));
         tick;
      end

      // reset with reads queued and in flight
      ack_out_b = 3'b010;
      for (int i = 1; i <= 3; i++) begin
         rin_b = pkt(RD, 4'(i), 16'h1, 32'h0);
         tick;
      end
      rin_b = '0;
      tick;
      tick;
      check("pre_lvl", 64'(lvl_b), 64'd3);
      check("pre_hd", 64'(rou_b), rsp(4'd1, 16'h1, 32'h21));
      rin_b = pkt(RD, 4'd4, 16'h1, 32'h0);
      tick;
      rin_b = pkt(RD, 4'd5, 16'h1, 32'h0);
      tick;
      check("fly_lvl", 64'(lvl_b), 64'd5);
      rin_b = '0;
      rst_n = 1'b0;
      tick;
      check("mr_rou", 64'(rou_b), 64'd0);
      check("mr_ack", 64'(ack_in_b), 64'd0);
      check("mr_lvl", 64'(lvl_b), 64'd0);
      check("mr_erra", 64'(err_a), 64'd0);
      check("mr_roua", 64'(rou_a), 64'd0);
      rst_n     = 1'b1;
      ack_out_b = 3'b001;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("no_stale", 64'(rou_b), 64'd0);
      end
      rin_b = pkt(RD, 4'd9, 16'h1, 32'h0);
      rin_a = pkt(RD, 4'd3, 16'h105, 32'h0);
      tick;
      check("pr_ackb", 64'(ack_in_b), 64'd1);
      check("pr_acka", 64'(ack_in_a), 64'd1);
      rin_b = '0;
      rin_a = '0;
      tick;
      tick;
      check("pr_rdb", 64'(rou_b), rsp(4'd9, 16'h1, 32'h21));
      check("pr_rda", 64'(rou_a), rsp(4'd3, 16'h105, 32'hA5));
      tick;

      // error counter saturation
      rin_a = pkt(RS, 4'd0, 16'h0, 32'h0);
      repeat (65534) tick;
      check("sat_ack", 64'(ack_in_a), 64'd4);
      check("sat_m1", 64'(err_a), 64'hFFFE);
      repeat (70000 - 65534) tick;
      check("sat_max", 64'(err_a), 64'hFFFF);
      rin_a = '0;
      tick;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
